// File: rtl/hamming_secded_decoder_pkg.sv
// Shared types and constants for the Hamming(16,11) SECDED byte-pair decoder.
package hamming_secded_decoder_pkg;

  typedef enum logic [2:0] {
    IN_LO  = 3'd0,
    IN_HI  = 3'd1,
    DEC    = 3'd2,
    OUT_LO = 3'd3,
    OUT_HI = 3'd4
  } dec_state_t;

  localparam logic [1:0] kNOERR = 2'b00;
  localparam logic [1:0] kCORR  = 2'b01;
  localparam logic [1:0] kDERR  = 2'b10;

  // Observability bundle: FSM state plus the live syndrome of the held word.
  typedef struct packed {
    dec_state_t state;
    logic [3:0] synd;
    logic       parity;
  } dec_dbg_t;

endpackage

// File: rtl/hamming_secded_decoder_syndrome.sv
// Combinational SECDED check of one 16-bit word: syndrome, overall parity,
// corrected data bits and the error flag.
module hamming_syndrome
  import hamming_secded_decoder_pkg::*;
(
  input  logic [15:0] word_i,
  output logic [3:0]  synd_o,
  output logic        parity_o,
  output logic [10:0] data_o,
  output logic [1:0]  flag_o
);

  logic [15:0] fixed;

  always_comb begin
    // XOR of the positions of all set bits equals {s8,s4,s2,s1}.
    synd_o = 4'd0;
    for (int k = 1; k < 16; k++) begin
      if (word_i[k]) synd_o = synd_o ^ 4'(k);
    end
    parity_o = ^word_i;

    fixed = word_i;
    if ((synd_o != 4'd0) && parity_o) fixed[synd_o] = ~word_i[synd_o];

    data_o = {fixed[15:9], fixed[7:5], fixed[3]};

    flag_o = kNOERR;
    if (parity_o)              flag_o = kCORR;
    else if (synd_o != 4'd0)   flag_o = kDERR;
  end

endmodule

// File: rtl/hamming_secded_decoder.sv
// Byte-stream SECDED decoder: gathers two bytes per word, decodes in one
// cycle, emits two result bytes and keeps saturating error counts.
module hamming_secded_decoder
  import hamming_secded_decoder_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [7:0]       out_data,
  input  logic             out_ready,
  output logic [CNT_W-1:0] cnt_single,
  output logic [CNT_W-1:0] cnt_double,
  output dec_dbg_t         dbg
);

  // Handshake: a byte moves on a rising edge where valid && ready; valid and
  // data are held by the producer until that edge.

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  dec_state_t       state_q;
  logic [15:0]      word_q;
  logic [7:0]       out_data_q;
  logic [7:0]       res_hi_q;
  logic             out_valid_q;
  logic             in_ready_q;
  logic [CNT_W-1:0] cnt_single_q, cnt_single_d;
  logic [CNT_W-1:0] cnt_double_q, cnt_double_d;

  logic [3:0]  synd;
  logic        parity;
  logic [10:0] data;
  logic [1:0]  flag;

  hamming_syndrome u_syndrome (
    .word_i   (word_q),
    .synd_o   (synd),
    .parity_o (parity),
    .data_o   (data),
    .flag_o   (flag)
  );

  always_comb begin
    cnt_single_d = cnt_single_q;
    cnt_double_d = cnt_double_q;
    if (flag == kCORR && cnt_single_q != CNT_MAX) cnt_single_d = cnt_single_q + 1'b1;
    if (flag == kDERR && cnt_double_q != CNT_MAX) cnt_double_d = cnt_double_q + 1'b1;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q      <= IN_LO;
      word_q       <= 16'h0000;
      out_data_q   <= 8'h00;
      res_hi_q     <= 8'h00;
      out_valid_q  <= 1'b0;
      in_ready_q   <= 1'b1;
      cnt_single_q <= '0;
      cnt_double_q <= '0;
    end else begin
      case (state_q)
        IN_LO: if (in_valid && in_ready_q) begin
          word_q[7:0] <= in_data;
          state_q     <= IN_HI;
        end
        IN_HI: if (in_valid && in_ready_q) begin
          word_q[15:8] <= in_data;
          in_ready_q   <= 1'b0;
          state_q      <= DEC;
        end
        DEC: begin
          out_data_q   <= data[7:0];
          res_hi_q     <= {flag, 3'b000, data[10:8]};
          out_valid_q  <= 1'b1;
          cnt_single_q <= cnt_single_d;
          cnt_double_q <= cnt_double_d;
          state_q      <= OUT_LO;
        end
        OUT_LO: if (out_ready) begin
          out_data_q <= res_hi_q;
          state_q    <= OUT_HI;
        end
        OUT_HI: if (out_ready) begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= IN_LO;
        end
        default: state_q <= IN_LO;
      endcase
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign cnt_single = cnt_single_q;
  assign cnt_double = cnt_double_q;
  assign dbg        = '{state: state_q, synd: synd, parity: parity};

endmodule

// File: tb/tb_hamming_secded_decoder.sv
// Bench for hamming_secded_decoder: directed vectors, backpressure, reset,
// counter saturation (second instance with 2-bit counters) and random words.
module tb_hamming_secded_decoder;
  import hamming_secded_decoder_pkg::*;

  // ---------------- clock / reset ----------------
  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic       Reset, in_valid, out_ready;
  logic [7:0] in_data;

  logic       a_in_ready, a_out_valid;
  logic [7:0] a_out_data, a_cnt_s, a_cnt_d;
  dec_dbg_t   a_dbg;
  logic       b_in_ready, b_out_valid;
  logic [7:0] b_out_data;
  logic [1:0] b_cnt_s, b_cnt_d;
  dec_dbg_t   b_dbg;

  hamming_secded_decoder #(.CNT_W(8)) dut_a (
    .Clk(Clk), .Reset(Reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(a_in_ready), .out_valid(a_out_valid), .out_data(a_out_data),
    .out_ready(out_ready), .cnt_single(a_cnt_s), .cnt_double(a_cnt_d), .dbg(a_dbg)
  );

  hamming_secded_decoder #(.CNT_W(2)) dut_b (
    .Clk(Clk), .Reset(Reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(b_in_ready), .out_valid(b_out_valid), .out_data(b_out_data),
    .out_ready(out_ready), .cnt_single(b_cnt_s), .cnt_double(b_cnt_d), .dbg(b_dbg)
  );

  // ---------------- scoreboard state ----------------
  int         n_cmp = 0;
  int         n_err = 0;
  int         exp_s = 0;
  int         exp_d = 0;
  logic [7:0] exp_q[$];
  int         dpos[11] = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  function automatic logic [15:0] encode(input logic [10:0] d);
    logic [15:0] w;
    logic        x;
    w = 16'h0000;
    for (int i = 0; i < 11; i++) w[dpos[i]] = d[i];
    for (int p = 1; p < 16; p = p * 2) begin
      x = 1'b0;
      for (int k = 1; k < 16; k++)
        if (((k & p) != 0) && (k != p)) x = x ^ w[k];
      w[p] = x;
    end
    w[0] = ^w[15:1];
    return w;
  endfunction

  function automatic logic [10:0] extract(input logic [15:0] w);
    logic [10:0] d;
    for (int i = 0; i < 11; i++) d[i] = w[dpos[i]];
    return d;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic send_byte(input logic [7:0] b);
    int n;
    in_data  = b;
    in_valid = 1'b1;
    n = 0;
    while (!a_in_ready && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) chk("in_ready_timeout", 32'(a_in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic recv_byte();
    int n;
    int stall;
    n = 0;
    while (!a_out_valid && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) chk("out_valid_timeout", 32'(a_out_valid), 32'd1);
    stall = $urandom_range(0, 3);
    out_ready = 1'b0;
    repeat (stall) begin
      chk("stall_valid", 32'(a_out_valid), 32'd1);
      chk("stall_data", 32'(a_out_data), 32'(exp_q[0]));
      tick();
    end
    chk("out_byte", 32'(a_out_data), 32'(exp_q[0]));
    chk("out_byte_b", 32'(b_out_data), 32'(exp_q[0]));
    void'(exp_q.pop_front());
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic bump(input int kind);
    if (kind == 1) exp_s++;
    if (kind == 2) exp_d++;
  endtask

  task automatic check_counters(input string tag);
    chk({tag, "_cnt_single"},   32'(a_cnt_s), 32'((exp_s > 255) ? 255 : exp_s));
    chk({tag, "_cnt_double"},   32'(a_cnt_d), 32'((exp_d > 255) ? 255 : exp_d));
    chk({tag, "_cnt_single_b"}, 32'(b_cnt_s), 32'((exp_s > 3) ? 3 : exp_s));
    chk({tag, "_cnt_double_b"}, 32'(b_cnt_d), 32'((exp_d > 3) ? 3 : exp_d));
  endtask

  task automatic run_word(input string tag, input logic [7:0] lo, input logic [7:0] hi,
                          input logic [7:0] elo, input logic [7:0] ehi, input int kind);
    exp_q.push_back(elo);
    exp_q.push_back(ehi);
    bump(kind);
    send_byte(lo);
    send_byte(hi);
    chk({tag, "_lat_dec"}, 32'(a_out_valid), 32'd0);
    tick();
    chk({tag, "_lat_out"}, 32'(a_out_valid), 32'd1);
    recv_byte();
    recv_byte();
    chk({tag, "_in_ready_after"}, 32'(a_in_ready), 32'd1);
    check_counters(tag);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [10:0] d, dx;
    logic [15:0] w;
    int          nf, p1, p2;
    logic [1:0]  f;

    Reset = 1'b1; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
    repeat (2) tick();
    Reset = 1'b0;
    chk("rst_in_ready",  32'(a_in_ready), 32'd1);
    chk("rst_out_valid", 32'(a_out_valid), 32'd0);
    chk("rst_out_data",  32'(a_out_data), 32'h00);
    chk("rst_state",     32'(a_dbg.state), 32'(IN_LO));
    check_counters("rst");

    run_word("clean0",  8'h00, 8'h00, 8'h00, 8'h00, 0);
    run_word("cleanF",  8'hFF, 8'hFF, 8'hFF, 8'h07, 0);
    run_word("sgl_b5",  8'h20, 8'h00, 8'h00, 8'h40, 1);
    run_word("sgl_b15", 8'hFF, 8'h7F, 8'hFF, 8'h47, 1);
    run_word("p0_only", 8'h01, 8'h00, 8'h00, 8'h40, 1);
    run_word("double",  8'h03, 8'h00, 8'h00, 8'h80, 2);

    // Backpressure: hold OUT_LO for 10 cycles with a stray input byte offered.
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h00);
    send_byte(8'h00);
    send_byte(8'h00);
    tick();
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin in_valid = 1'b1; in_data = 8'hAA; end
      if (i == 5) in_valid = 1'b0;
      chk("bp_valid",    32'(a_out_valid), 32'd1);
      chk("bp_data",     32'(a_out_data), 32'h00);
      chk("bp_in_ready", 32'(a_in_ready), 32'd0);
      tick();
    end
    recv_byte();
    recv_byte();
    check_counters("bp");
    run_word("after_bp", 8'hFF, 8'hFF, 8'hFF, 8'h07, 0);

    // Random words with 0, 1 or 2 injected bit errors.
    for (int t = 0; t < 40; t++) begin
      d  = 11'($urandom_range(0, 2047));
      w  = encode(d);
      nf = $urandom_range(0, 2);
      p1 = $urandom_range(0, 15);
      p2 = (p1 + $urandom_range(1, 15)) % 16;
      if (nf >= 1) w[p1] = ~w[p1];
      if (nf == 2) w[p2] = ~w[p2];
      dx = (nf == 2) ? extract(w) : d;
      f  = (nf == 0) ? kNOERR : ((nf == 1) ? kCORR : kDERR);
      run_word("rand", w[7:0], w[15:8], dx[7:0], {f, 3'b000, dx[10:8]}, nf);
    end

    // Reset after only the low byte of a word.
    send_byte(8'h5A);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    exp_s = 0;
    exp_d = 0;
    chk("mid_rst_in_ready",   32'(a_in_ready), 32'd1);
    chk("mid_rst_in_ready_b", 32'(b_in_ready), 32'd1);
    chk("mid_rst_state",      32'(a_dbg.state), 32'(IN_LO));
    chk("mid_rst_state_b",    32'(b_dbg.state), 32'(IN_LO));
    check_counters("mid_rst");
    for (int i = 0; i < 5; i++) begin
      chk("mid_rst_no_out",   32'(a_out_valid), 32'd0);
      chk("mid_rst_no_out_b", 32'(b_out_valid), 32'd0);
      tick();
    end
    w = encode(11'h5A3);
    run_word("post_rst", w[7:0], w[15:8], 8'hA3, 8'h05, 0);

    // Saturation: the 2-bit counter instance stops at 3.
    for (int i = 0; i < 5; i++) run_word("sat", 8'h20, 8'h00, 8'h00, 8'h40, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/hamming_secded_decoder.md
Name: hamming_secded_decoder

Overview:
- Decoder side of the Hamming(16,11) SECDED byte-pair format that the program-1 parity generator produces.
- Accepts encoded words as a byte stream, two bytes per word, low byte first.
- For each word: corrects any single-bit error, detects double errors, and emits two result bytes (low byte first) carrying the 11 data bits plus a 2-bit error flag.
- Keeps saturating counts of corrected words and double-error words for software/bench readback.

Parameters:
CNT_W, 8, width of each error counter (saturates at all-ones)

Ports:
Clk        input   1      clock; all state updates on rising edge
Reset      input   1      synchronous, active-high reset
in_valid   input   1      in_data holds a valid encoded byte
in_data    input   8      encoded byte: first low, then high
in_ready   output  1      decoder accepts in_data this cycle
out_valid  output  1      out_data holds a valid result byte
out_data   output  8      result byte: first low, then high
out_ready  input   1      consumer accepts out_data this cycle
cnt_single output  CNT_W  words with a single error corrected (includes p0-only errors)
cnt_double output  CNT_W  words flagged as double error

Behaviour:
- Reset: one clock, synchronous, active-high. Ports are Clk and Reset.
- Word layout: W[15:0] = {hi, lo}.
  - W[0] = p0, overall parity of all 16 bits.
  - W[k], k=1..15, is Hamming position k: p1=W1, p2=W2, p4=W4, p8=W8.
  - Data bits: b1=W3, b2=W5, b3=W6, b4=W7, b5..b11=W9..W15.
- Handshakes: a byte transfers when valid && ready on a rising edge. out_data and out_valid come from registers and must stay stable until accepted.
- FSM states: IN_LO, IN_HI, DEC, OUT_LO, OUT_HI.
  - IN_LO: in_ready=1. On handshake, latch lo and go to IN_HI.
  - IN_HI: in_ready=1. On handshake, latch hi and go to DEC.
  - DEC: in_ready=0, out_valid=0. In one cycle compute syndrome and flags, register the results, update counters, go to OUT_LO.
  - OUT_LO: out_valid=1, out_data=b8..b1. On handshake go to OUT_HI.
  - OUT_HI: out_valid=1, out_data={F1,F0,3'b000,b11,b10,b9}. On handshake go to IN_LO.
- in_ready=0 in DEC, OUT_LO and OUT_HI. The next word's low byte can be accepted, at the earliest, the cycle after the OUT_HI handshake.
- Minimum 5 cycles per word. Latency from the hi-byte handshake to out_valid=1 is 2 edges.
- Syndrome: s = {s8,s4,s2,s1}, where s_j = XOR of W[k] over all k in 1..15 with bit j of k set. q = XOR of W[15:0].
- Decode cases:
  - s=0, q=0: no error, F=00.
  - s=0, q=1: p0 error only. Data unchanged, F=01, cnt_single++.
  - s!=0, q=1: single error. Flip W[s] before extracting data, F=01, cnt_single++.
  - s!=0, q=0: double error. Data extracted uncorrected, F=10, cnt_double++.
  - F=11 is never produced.
- Counters hold at 2^CNT_W-1; they do not wrap.
- Reset values: state=IN_LO, in_ready=1, out_valid=0, out_data=8'h00, cnt_single=0, cnt_double=0, internal word/result registers=0.
- Reset mid-operation, in any state: a partially received or partially emitted word is discarded, no result byte is emitted for it, and counters clear.
- in_valid while in_ready=0 is ignored; no byte is consumed.

Decomposition:
- Package definitions:
  - FSM state enum: dec_state_t {IN_LO, IN_HI, DEC, OUT_LO, OUT_HI}.
  - Flag constants: kNOERR=2'b00, kCORR=2'b01, kDERR=2'b10.
- Sub-module hamming_syndrome (combinational):
  - Input: W[15:0].
  - Outputs: s[3:0], q, corrected data[10:0], flag[1:0].
  - The top level holds only the FSM, registers, handshakes and counters.

Test Plan:
- Clean words: input 8'h00, 8'h00 -> out 8'h00, 8'h00. Input 8'hFF, 8'hFF -> out 8'hFF, 8'h07. Both counters stay 0.
- Single error:
  - Input 8'h20, 8'h00 (bit 5 flipped) -> out 8'h00, 8'h40.
  - Input 8'hFF, 8'h7F (bit 15 flipped) -> out 8'hFF, 8'h47.
  - cnt_single=2 after both.
- p0-only error: input 8'h01, 8'h00 -> out 8'h00, 8'h40, cnt_single++.
- Double error: input 8'h03, 8'h00 -> out 8'h00, 8'h80, cnt_double=1.
- Backpressure:
  - Hold out_ready=0 for 10 cycles in OUT_LO -> out_data stays 8'h00, out_valid stays 1, in_ready stays 0.
  - Then raise out_ready -> both bytes emitted in order.
  - A third in_valid pulse during the stall is not consumed.
- Reset mid-op and saturation:
  - Assert Reset after the low byte of a word -> in_ready=1, no output bytes, counters 0; the next full clean word decodes correctly.
  - With CNT_W=2, send 5 single-error words -> cnt_single=3.
